can_rx: RTL

CAN_RX -- requirements
Module: can_rx

---
 rtl/can_rx.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/can_rx.sv
`default_nettype none
// ============================================================================
// Module   : can_rx
// Brief    : CAN 2.0A/B frame receiver: bit timing, destuffing, CRC-15 check,
//            ACK drive and error recovery.
// Revision : 1.0
// ============================================================================
module can_rx #(
    parameter int RECOV_BITS = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  quantaDiv,
    input  logic [5:0]  propQuanta,
    input  logic [5:0]  seg1Quanta,
    input  logic        din,
    output logic        dout,
    output logic        ddrive,
    output logic [63:0] rxdata,
    output logic [28:0] rxid,
    output logic        rxformat,
    output logic        rxrtr,
    output logic [3:0]  rxdatalen,
    output logic        rxvalid,
    output logic        rxerr,
    output logic [1:0]  rxerrcode,
    output logic        busy
);
    localparam int c_RECOV_W = $clog2(RECOV_BITS + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SOF     = 4'd1,
        S_ARB     = 4'd2,
        S_CTRL    = 4'd3,
        S_DATA    = 4'd4,
        S_CRC     = 4'd5,
        S_CRCDEL  = 4'd6,
        S_ACK     = 4'd7,
        S_ACKDEL  = 4'd8,
        S_EOF     = 4'd9,
        S_RECOVER = 4'd10
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_div;
    logic [5:0]             r_prop;
    logic [5:0]             r_seg1;
    logic [7:0]             r_clkcnt;
    logic [7:0]             r_qcnt;
    logic [5:0]             r_bitcnt;
    logic [6:0]             r_nbits;
    logic [14:0]            r_crc;
    logic [2:0]             r_stuff_cnt;
    logic                   r_stuff_last;
    logic                   r_din_prev;
    logic [28:0]            r_id;
    logic [63:0]            r_data;
    logic                   r_rtr;
    logic                   r_ide;
    logic [3:0]             r_dlc;
    logic                   r_crc_ok;
    logic [c_RECOV_W-1:0]   r_recov;

    logic [7:0]  w_qmax;
    logic [7:0]  w_spt;
    logic        w_last_clk;
    logic        w_sample;
    logic        w_bitend;
    logic        w_in_frame;
    logic        w_stuff_bit;
    logic [14:0] w_crc_next;
    logic [3:0]  w_dlc;
    logic [3:0]  w_bytes;
    logic [4:0]  w_id_idx;

    assign w_qmax      = {2'b00, r_prop} + {1'b0, r_seg1, 1'b0};
    assign w_spt       = {2'b00, r_prop} + {2'b00, r_seg1};
    assign w_last_clk  = (r_clkcnt == r_div);
    assign w_sample    = w_last_clk && (r_qcnt == w_spt);
    assign w_bitend    = w_last_clk && (r_qcnt >= w_qmax);
    assign w_in_frame  = r_state inside {S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC};
    // A stuff bit may still follow the last CRC bit, i.e. land in the CRCDEL slot.
    assign w_stuff_bit = (w_in_frame || r_state == S_CRCDEL) && (r_stuff_cnt == 3'd5);
    assign w_crc_next  = {r_crc[13:0], 1'b0} ^ ((din ^ r_crc[14]) ? 15'h4599 : 15'h0000);
    assign w_dlc       = {r_dlc[2:0], din};
    assign w_bytes     = r_rtr ? 4'd0 : ((w_dlc > 4'd8) ? 4'd8 : w_dlc);
    assign w_id_idx    = (r_bitcnt <= 6'd10) ? 5'(6'd28 - r_bitcnt) : 5'(6'd30 - r_bitcnt);
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= 8'd0;
            r_prop       <= 6'd0;
            r_seg1       <= 6'd0;
            r_clkcnt     <= 8'd0;
            r_qcnt       <= 8'd0;
            r_bitcnt     <= 6'd0;
            r_nbits      <= 7'd0;
            r_crc        <= 15'd0;
            r_stuff_cnt  <= 3'd0;
            r_stuff_last <= 1'b0;
            r_din_prev   <= 1'b1;
            r_id         <= 29'd0;
            r_data       <= 64'd0;
            r_rtr        <= 1'b0;
            r_ide        <= 1'b0;
            r_dlc        <= 4'd0;
            r_crc_ok     <= 1'b0;
            r_recov      <= '0;
            dout         <= 1'b1;
            ddrive       <= 1'b0;
            rxdata       <= 64'd0;
            rxid         <= 29'd0;
            rxformat     <= 1'b0;
            rxrtr        <= 1'b0;
            rxdatalen    <= 4'd0;
            rxvalid      <= 1'b0;
            rxerr        <= 1'b0;
            rxerrcode    <= 2'd0;
        end else begin
            r_din_prev <= din;
            rxvalid    <= 1'b0;
            rxerr      <= 1'b0;
            if (r_state == S_IDLE) begin
                if (r_din_prev && !din) begin
                    // This edge is clk 0 of sync quantum 0; position counters for the next edge.
                    r_div        <= quantaDiv;
                    r_prop       <= propQuanta;
                    r_seg1       <= seg1Quanta;
                    r_clkcnt     <= (quantaDiv == 8'd0) ? 8'd0 : 8'd1;
                    r_qcnt       <= (quantaDiv == 8'd0) ? 8'd1 : 8'd0;
                    r_bitcnt     <= 6'd0;
                    r_crc        <= 15'd0;
                    r_stuff_cnt  <= 3'd0;
                    r_stuff_last <= 1'b0;
                    r_id         <= 29'd0;
                    r_data       <= 64'd0;
                    r_rtr        <= 1'b0;
                    r_ide        <= 1'b0;
                    r_dlc        <= 4'd0;
                    r_crc_ok     <= 1'b0;
                    r_state      <= S_SOF;
                end
            end else begin
                if (w_last_clk) begin
                    r_clkcnt <= 8'd0;
                    r_qcnt   <= (r_qcnt >= w_qmax) ? 8'd0 : r_qcnt + 8'd1;
                end else begin
                    r_clkcnt <= r_clkcnt + 8'd1;
                end
                if (w_bitend) begin
                    dout   <= !(r_state == S_ACK && r_crc_ok);
                    ddrive <= (r_state == S_ACK && r_crc_ok);
                end
                if (w_sample) begin
                    if (w_stuff_bit) begin
                        if (din == r_stuff_last) begin
                            r_state   <= S_RECOVER;
                            r_recov   <= '0;
                            rxerr     <= 1'b1;
                            rxerrcode <= 2'd0;
                        end else begin
                            r_stuff_last <= din;
                            r_stuff_cnt  <= 3'd1;
                        end
                    end else begin
                        if (w_in_frame) begin
                            r_stuff_last <= din;
                            r_stuff_cnt  <= (r_stuff_cnt != 3'd0 && din == r_stuff_last) ?
                                            r_stuff_cnt + 3'd1 : 3'd1;
                            // Running through the received CRC too leaves zero on a match.
                            r_crc        <= w_crc_next;
                        end
                        case (r_state)
                            S_SOF: begin
                                if (din) begin
                                    r_state   <= S_IDLE;
                                    rxerr     <= 1'b1;
                                    rxerrcode <= 2'd3;
                                end else begin
                                    r_state  <= S_ARB;
                                    r_bitcnt <= 6'd0;
                                end
                            end
                            S_ARB: begin
                                r_bitcnt <= r_bitcnt + 6'd1;
                                if (r_bitcnt == 6'd11 || r_bitcnt == 6'd31) begin
                                    r_rtr <= din;
                                end else if (r_bitcnt == 6'd12) begin
                                    r_ide <= din;
                                    if (!din) begin
                                        r_state  <= S_CTRL;
                                        r_bitcnt <= 6'd0;
                                    end
                                end else if (r_bitcnt <= 6'd30) begin
                                    r_id[w_id_idx] <= din;
                                end else begin
                                    r_state  <= S_CTRL;
                                    r_bitcnt <= 6'd0;
                                end
                            end
                            S_CTRL: begin
                                r_bitcnt <= r_bitcnt + 6'd1;
                                if (r_bitcnt != 6'd0) begin
                                    r_dlc <= w_dlc;
                                end
                                if (r_bitcnt == 6'd4) begin
                                    r_nbits  <= {w_bytes, 3'b000};
                                    r_bitcnt <= 6'd0;
                                    r_state  <= (w_bytes == 4'd0) ? S_CRC : S_DATA;
                                end
                            end
                            S_DATA: begin
                                r_data[6'd63 - r_bitcnt] <= din;
                                r_bitcnt <= r_bitcnt + 6'd1;
                                if ({1'b0, r_bitcnt} == r_nbits - 7'd1) begin
                                    r_bitcnt <= 6'd0;
                                    r_state  <= S_CRC;
                                end
                            end
                            S_CRC: begin
                                r_bitcnt <= r_bitcnt + 6'd1;
                                if (r_bitcnt == 6'd14) begin
                                    r_bitcnt <= 6'd0;
                                    r_state  <= S_CRCDEL;
                                end
                            end
                            S_CRCDEL: begin
                                if (!din) begin
                                    r_state   <= S_RECOVER;
                                    r_recov   <= '0;
                                    rxerr     <= 1'b1;
                                    rxerrcode <= 2'd2;
                                end else begin
                                    r_crc_ok <= (r_crc == 15'd0);
                                    r_state  <= S_ACK;
                                end
                            end
                            S_ACK: begin
                                r_state <= S_ACKDEL;
                            end
                            S_ACKDEL: begin
                                if (!r_crc_ok || !din) begin
                                    r_state   <= S_RECOVER;
                                    r_recov   <= '0;
                                    rxerr     <= 1'b1;
                                    rxerrcode <= r_crc_ok ? 2'd2 : 2'd1;
                                end else begin
                                    r_state  <= S_EOF;
                                    r_bitcnt <= 6'd0;
                                end
                            end
                            S_EOF: begin
                                r_bitcnt <= r_bitcnt + 6'd1;
                                if (!din) begin
                                    r_state   <= S_RECOVER;
                                    r_recov   <= '0;
                                    rxerr     <= 1'b1;
                                    rxerrcode <= 2'd2;
                                end else if (r_bitcnt == 6'd6) begin
                                    r_state   <= S_IDLE;
                                    rxvalid   <= 1'b1;
                                    rxdata    <= r_data;
                                    rxid      <= r_id;
                                    rxformat  <= r_ide;
                                    rxrtr     <= r_rtr;
                                    rxdatalen <= r_dlc;
                                end
                            end
                            S_RECOVER: begin
                                if (!din) begin
                                    r_recov <= '0;
                                end else if (r_recov == c_RECOV_W'(RECOV_BITS - 1)) begin
                                    r_state <= S_IDLE;
                                end else begin
                                    r_recov <= r_recov + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire
